// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready flow control.
// Define BK_ADDER_OVF_EN to add the out_ovf signed-overflow output.
module bk_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_g,
  output logic             out_p
`ifdef BK_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LOG2W  = $clog2(WIDTH);
  localparam int LEVELS = 2 * LOG2W - 1;

  // Rank j (0..STAGES-2) sits after prefix level ceil((j+1)*LEVELS/STAGES).
  function automatic int rank_of_level(int lvl);
    int r = -1;
    for (int j = 0; j < STAGES - 1; j++)
      if (((j + 1) * LEVELS + STAGES - 1) / STAGES == lvl) r = j;
    return r;
  endfunction

  // ---------------- flow control ----------------
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_ld_data;

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    w_load = '0;
    for (int j = 0; j < STAGES; j++) begin
      w_load[j] = out_ready;
      for (int k = j; k < STAGES; k++)
        if (!r_vld[k]) w_load[j] = 1'b1;
    end
  end

  assign w_vin     = (r_vld << 1) | STAGES'(in_valid);
  assign w_ld_data = w_load & w_vin;
  assign in_ready  = w_load[0] & rst_n;
  assign out_valid = r_vld[STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so all ranks advance off the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      for (int j = 0; j < STAGES; j++)
        if (w_load[j]) r_vld[j] <= w_vin[j];
    end
  end

  // ---------------- prefix datapath ----------------
  logic [WIDTH-1:0] w_g_out  [0:LEVELS];
  logic [WIDTH-1:0] w_p_out  [0:LEVELS];
  logic [WIDTH-1:0] w_pb_out [0:LEVELS];
  logic             w_c0_out [0:LEVELS];
  logic [WIDTH-1:0] w_g_in   [1:LEVELS+1];
  logic [WIDTH-1:0] w_p_in   [1:LEVELS+1];
  logic [WIDTH-1:0] w_pb_in  [1:LEVELS+1];
  logic             w_c0_in  [1:LEVELS+1];
  logic [WIDTH-1:0] w_b;

  assign w_b         = in_sub ? ~in_b : in_b;
  assign w_g_out[0]  = in_a & w_b;
  assign w_p_out[0]  = in_a ^ w_b;
  assign w_pb_out[0] = in_a ^ w_b;
  assign w_c0_out[0] = in_sub | in_cin;

  // Levels 1..LOG2W are the up-sweep, the rest the down-sweep filling the gaps.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    assign w_pb_out[l] = w_pb_in[l];
    assign w_c0_out[l] = w_c0_in[l];
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit UP     = (l <= LOG2W);
      localparam int SPAN   = UP ? (1 << (l - 1)) : (1 << (2 * LOG2W - l - 1));
      localparam bit ACTIVE = UP ? ((i + 1) % (2 * SPAN) == 0)
                                 : (((i + 1) % (2 * SPAN) == SPAN) && (i >= 2 * SPAN));
      if (ACTIVE) begin : g_op
        assign w_g_out[l][i] = w_g_in[l][i] | (w_p_in[l][i] & w_g_in[l][i-SPAN]);
        assign w_p_out[l][i] = w_p_in[l][i] & w_p_in[l][i-SPAN];
      end else begin : g_pass
        assign w_g_out[l][i] = w_g_in[l][i];
        assign w_p_out[l][i] = w_p_in[l][i];
      end
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_bnd
    localparam int RK = rank_of_level(l);
    if (RK >= 0) begin : g_reg
      logic [WIDTH-1:0] r_g, r_p, r_pb;
      logic             r_c0;
      // NOTE: datapath ranks are reset as well, so every output reads a defined 0 straight out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_g  <= '0;
          r_p  <= '0;
          r_pb <= '0;
          r_c0 <= 1'b0;
        end else if (w_ld_data[RK]) begin
          r_g  <= w_g_out[l];
          r_p  <= w_p_out[l];
          r_pb <= w_pb_out[l];
          r_c0 <= w_c0_out[l];
        end
      end
      assign w_g_in[l+1]  = r_g;
      assign w_p_in[l+1]  = r_p;
      assign w_pb_in[l+1] = r_pb;
      assign w_c0_in[l+1] = r_c0;
    end else begin : g_wire
      assign w_g_in[l+1]  = w_g_out[l];
      assign w_p_in[l+1]  = w_p_out[l];
      assign w_pb_in[l+1] = w_pb_out[l];
      assign w_c0_in[l+1] = w_c0_out[l];
    end
  end

  // ---------------- carry fold-in and output rank ----------------
  logic [WIDTH-1:0] w_g_fin, w_p_fin, w_pb_fin, w_sum;
  logic             w_c0_fin;
  logic [WIDTH:0]   w_c;

  assign w_g_fin  = w_g_in[LEVELS+1];
  assign w_p_fin  = w_p_in[LEVELS+1];
  assign w_pb_fin = w_pb_in[LEVELS+1];
  assign w_c0_fin = w_c0_in[LEVELS+1];
  // c0 acts as the generate of bit -1: c(i+1) = G[i:0] | P[i:0]&c0.
  assign w_c      = {w_g_fin | (w_p_fin & {WIDTH{w_c0_fin}}), w_c0_fin};
  assign w_sum    = w_pb_fin ^ w_c[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_g    <= 1'b0;
      out_p    <= 1'b0;
`ifdef BK_ADDER_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else if (w_ld_data[STAGES-1]) begin
      out_sum  <= w_sum;
      out_cout <= w_c[WIDTH];
      out_g    <= w_g_fin[WIDTH-1];
      out_p    <= w_p_fin[WIDTH-1];
`ifdef BK_ADDER_OVF_EN
      out_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed cases on a 32-bit/2-stage instance,
// plus concurrent randomized instances over several WIDTH/STAGES points against an arithmetic model.
module tb_bk_adder_pipe;

  localparam int NCFG  = 10;
  localparam int NRAND = 3000;

  function automatic int cfg_w(int i);
    case (i)
      0:       return 32;
      1, 2, 3: return 4;
      4, 5, 6: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 4;
      4: return 1;
      5: return 3;
      6: return 8;
      7: return 1;
      8: return 3;
      default: return 12;
    endcase
  endfunction

  typedef struct packed {
    logic        ovf;
    logic        g;
    logic        p;
    logic        cout;
    logic [63:0] sum;
  } res_t;

  // A +/- B computed as plain integer arithmetic on W bits.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [64:0] mask, aa, bb, full, gsum;
    res_t r;
    mask   = (65'd1 << w) - 65'd1;
    aa     = {1'b0, a} & mask;
    bb     = {1'b0, (sub ? ~b : b)} & mask;
    full   = aa + bb + 65'(sub ? 1'b1 : cin);
    gsum   = aa + bb;
    r.sum  = full[63:0] & mask[63:0];
    r.cout = full[w];
    r.g    = gsum[w];
    r.p    = ((aa ^ bb) & mask) == mask;
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_main_n, rst_rand_n;
  logic        m_valid, m_cin, m_sub, m_oready;
  logic [31:0] m_a, m_b;
  logic        m_iready, m_ovalid, m_cout, m_g, m_p, m_ovf;
  logic [31:0] m_sum;

  for (genvar ci = 0; ci < NCFG; ci++) begin : g_cfg
    localparam int W = cfg_w(ci);
    localparam int S = cfg_s(ci);

    logic         rst_n, in_valid, in_ready, in_cin, in_sub;
    logic         out_valid, out_ready, out_cout, out_g, out_p, out_ovf;
    logic [W-1:0] in_a, in_b, out_sum;
    res_t         q[$];
    res_t         e;
    int           n_acc = 0;
    int           n_pop = 0;

    bk_adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_g     (out_g),
      .out_p     (out_p)
`ifdef BK_ADDER_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
    );
`ifndef BK_ADDER_OVF_EN
    assign out_ovf = 1'b0;
`endif

    if (ci == 0) begin : g_main
      assign rst_n     = rst_main_n;
      assign in_valid  = m_valid;
      assign in_a      = m_a;
      assign in_b      = m_b;
      assign in_cin    = m_cin;
      assign in_sub    = m_sub;
      assign out_ready = m_oready;
      assign m_iready  = in_ready;
      assign m_ovalid  = out_valid;
      assign m_sum     = out_sum;
      assign m_cout    = out_cout;
      assign m_g       = out_g;
      assign m_p       = out_p;
      assign m_ovf     = out_ovf;
    end else begin : g_rand
      assign rst_n = rst_rand_n;
      initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        wait (rst_rand_n);
        while (n_acc < NRAND) begin
          @(negedge clk);
          in_valid  = $urandom_range(0, 3) != 0;
          in_a      = W'(rand_op());
          in_b      = W'(rand_op());
          in_cin    = 1'($urandom_range(0, 1));
          in_sub    = 1'($urandom_range(0, 1));
          out_ready = $urandom_range(0, 2) != 0;
          #3;
        end
        for (int k = 0; k < 500 && q.size() != 0; k++) begin
          @(negedge clk);
          in_valid  = 1'b0;
          out_ready = 1'($urandom_range(0, 1));
          #3;
        end
        check($sformatf("cfg%0d_drain_left", ci), 72'(q.size()), 72'(0));
        done_cnt++;
      end
    end

    // Scoreboard: inputs and outputs are stable between negedge+2 and the next posedge.
    always @(negedge clk) begin
      #2;
      if (!rst_n) begin
        q.delete();
      end else begin
        if (out_valid) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d_spurious_out_valid", ci), 72'(out_valid), 72'(0));
          end else begin
            e = q[0];
`ifndef BK_ADDER_OVF_EN
            e.ovf = 1'b0;
`endif
            check($sformatf("cfg%0d_w%0d_s%0d_result", ci, W, S),
                  72'({out_ovf, out_g, out_p, out_cout, 64'(out_sum)}), 72'(e));
            if (out_ready) begin
              void'(q.pop_front());
              n_pop++;
            end
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(model(W, 64'(in_a), 64'(in_b), in_cin, in_sub));
          n_acc++;
        end
      end
    end
  end

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] es,
                          input logic ec, input logic eg, input logic ep);
    int cyc;
    @(negedge clk);
    m_valid = 1'b1; m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_oready = 1'b1;
    #2;
    check({name, "_accept"}, 72'(m_iready), 72'(1));
    @(negedge clk);
    m_valid = 1'b0;
    cyc = 1;
    #2;
    while (!m_ovalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      #2;
    end
    check({name, "_latency"}, 72'(cyc), 72'(2));
    check({name, "_result"}, 72'({m_sum, m_cout, m_g, m_p}), 72'({es, ec, eg, ep}));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, pop0, seen, guard;
    rst_main_n = 1'b0;
    rst_rand_n = 1'b0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_oready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("reset_state", 72'({m_iready, m_ovalid, m_cout, m_g, m_p, m_sum}), 72'(0));
    @(negedge clk);
    rst_main_n = 1'b1;
    rst_rand_n = 1'b1;
    #2;
    check("ready_after_reset", 72'(m_iready), 72'(1));

    directed("add_wrap",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0);
    directed("sub_borrow", 32'd5,         32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_pos",    32'd7,         32'd5, 1'b0, 1'b1, 32'd2,         1'b1, 1'b1, 1'b0);
    directed("full_prop",  32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef BK_ADDER_OVF_EN
    directed("ovf_sub",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    check("ovf_flag", 72'(m_ovf), 72'(1));
`endif

    // Back-pressure: 10 operands, consumer stalls for 5 cycles mid-stream.
    repeat (3) @(negedge clk);
    pop0 = g_cfg[0].n_pop;
    sent = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      m_valid  = (sent < 10);
      m_a      = $urandom;
      m_b      = $urandom;
      m_cin    = 1'($urandom_range(0, 1));
      m_sub    = 1'($urandom_range(0, 1));
      m_oready = !(i >= 4 && i < 9);
      #2;
      if (i == 8) check("bp_full_in_ready", 72'(m_iready), 72'(0));
      if (i == 9) check("bp_release_in_ready", 72'(m_iready), 72'(1));
      if (m_valid && m_iready) sent++;
    end
    m_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_sent", 72'(sent), 72'(10));
    check("bp_no_loss", 72'(g_cfg[0].n_pop - pop0), 72'(10));

    // Reset with two results in flight.
    @(negedge clk);
    m_oready = 1'b0; m_valid = 1'b1; m_a = 32'd100; m_b = 32'd23; m_sub = 1'b0; m_cin = 1'b0;
    @(negedge clk);
    m_a = 32'd9; m_b = 32'd4; m_sub = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    #1;
    check("inflight_before_reset", 72'(m_ovalid), 72'(1));
    rst_main_n = 1'b0;
    #1;
    check("rst_out_valid", 72'(m_ovalid), 72'(0));
    check("rst_in_ready", 72'(m_iready), 72'(0));
    repeat (2) @(negedge clk);
    rst_main_n = 1'b1;
    m_oready   = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #2;
      seen += int'(m_ovalid);
    end
    check("rst_no_emit", 72'(seen), 72'(0));
    directed("post_rst", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0);

    // Random traffic on the main instance.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      m_valid  = 1'($urandom_range(0, 1));
      m_a      = $urandom;
      m_b      = $urandom;
      m_cin    = 1'($urandom_range(0, 1));
      m_sub    = 1'($urandom_range(0, 1));
      m_oready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    m_valid  = 1'b0;
    m_oready = 1'b1;
    repeat (5) @(negedge clk);
    check("main_drain_left", 72'(g_cfg[0].q.size()), 72'(0));

    guard = 0;
    while (done_cnt < NCFG - 1 && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    check("rand_configs_done", 72'(done_cnt), 72'(NCFG - 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bk_adder_pipe.md
# bk_adder_pipe

Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor built from the team's prefix-combine cells (G = Gh | Ph&Gl, P = Ph&Pl; carry c(j+1) = Gij | Pij&cj). It extends the single combinational prefix cell to a full WIDTH-bit datapath with configurable pipeline depth, add/subtract mode, carry chaining and valid/ready flow control. It sits between operand-issue logic and result writeback in the arithmetic datapath.

## Interface
Parameters:
- WIDTH, 32, operand width; power of two, 4..64.
- STAGES, 2, pipeline register ranks; 1..(2*log2(WIDTH)); latency in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add mode only).
- in_sub  in  1  1 = A-B, 0 = A+B+cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- out_g  out  1  group generate G[WIDTH-1:0], for external chaining.
- out_p  out  1  group propagate P[WIDTH-1:0].

## Operation
- Bit level: b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin; g_i = a_i&b'_i, p_i = a_i^b'_i.
- Prefix tree: Brent-Kung, log2(WIDTH) up-sweep levels + log2(WIDTH)-1 down-sweep levels (L = 2*log2(WIDTH)-1), c0 folded in as bit -1 generate. sum_i = p_i ^ c_i; cout = c_WIDTH.
- out_g/out_p are the group terms of the whole word excluding c0; out_cout = out_g | out_p&c0.
- Pipeline ranks placed after prefix level ceil(k*L/STAGES), k=1..STAGES-1, final rank at outputs. Functional result independent of placement.
- Each rank holds a valid bit; rank k loads when empty or rank k+1 loads (last rank: when out_valid=0 or out_ready=1). Bubbles collapse.
- in_ready = rank 0 can load (combinational from out_ready through the valid chain); forced 0 while rst_n low.
- Transfer occurs only when valid&ready both high at a rising edge; stalled ranks hold data and valid unchanged.
- All arithmetic modulo 2^WIDTH; no saturation.

## Timing
- Reset (async, rst_n=0): all valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_g=0, out_p=0; in_ready=0. First cycle after release: in_ready=1.
- Latency: operands accepted at edge n appear with out_valid=1 after edge n+STAGES-1 (STAGES cycles incl. acceptance).
- Throughput 1 result/cycle with out_ready held 1.
- Full: all STAGES ranks valid and out_ready=0 -> in_ready=0; in_ready returns to 1 in the same cycle out_ready rises.
- Simultaneous out accept and in accept on a full pipe: both occur, no bubble, no loss.
- out_* stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all in-flight results discarded, no output produced for them.

## Configuration
- BK_ADDER_OVF_EN defined: extra port out_ovf (out, 1) = signed overflow, c_WIDTH ^ c_(WIDTH-1), pipelined with the result, reset 0.
- Undefined: port and logic absent; all other behaviour identical.

## Test plan
- WIDTH=32, STAGES=2: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> sum=0x00000000, cout=1, g=1, p=0, out_valid 2 cycles after accept.
- sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0; a=7, b=5 -> sum=2, cout=1; ovf (if BK_ADDER_OVF_EN) a=0x7FFFFFFF, b=0xFFFFFFFF sub=1 -> ovf=1.
- a=0xAAAAAAAA, b=0x55555555, cin=1 -> sum=0, cout=1, g=0, p=1 (full propagate chain).
- Back-pressure: stream 10 operands, out_ready=0 for 5 cycles mid-stream -> in_ready=0 after STAGES fills, no drop/duplicate, order preserved vs. reference model.
- Assert rst_n=0 with 2 results in flight -> out_valid=0 immediately, nothing emitted after release; next accepted op correct.
- Random 10k ops for WIDTH in {4,16,64}, STAGES in {1,3,max}, random valid/ready -> all match A±B model.
